// File: rtl/lcd_pkg.sv
// Shared command/state encodings for the LCD command scheduler.
package lcd_pkg;

  localparam int unsigned CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_WRITE    = 3'd0;
  localparam logic [CMD_W-1:0] CMD_UP       = 3'd1;
  localparam logic [CMD_W-1:0] CMD_DOWN     = 3'd2;
  localparam logic [CMD_W-1:0] CMD_LEFT     = 3'd3;
  localparam logic [CMD_W-1:0] CMD_RIGHT    = 3'd4;
  localparam logic [CMD_W-1:0] CMD_AVERAGE  = 3'd5;
  localparam logic [CMD_W-1:0] CMD_MIRROR_X = 3'd6;
  localparam logic [CMD_W-1:0] CMD_MIRROR_Y = 3'd7;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_READY = 3'd1,
    S_ISSUE = 3'd2,
    S_GUARD = 3'd3,
    S_WAIT  = 3'd4,
    S_DRAIN = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  // WRITE ends the sequence; everything after it is discarded.
  function automatic logic is_terminal(input logic [CMD_W-1:0] cmd);
    return cmd == CMD_WRITE;
  endfunction

endpackage

// File: rtl/lcd_cmd_sched_fifo.sv
// Command FIFO for the scheduler: wrapping pointers, occupancy-based full/empty, sync clear.
module sched_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [CMD_W-1:0]       wdata,
  input  logic                   pop,
  output logic [CMD_W-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Host-to-LCD-controller command scheduler. Optional busy watchdog built when
// LCD_SCHED_WDOG_EN is defined; otherwise wdog_err is tied low.
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WDOG_CYC = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CMD_W-1:0]       host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [CMD_W-1:0]       lcd_cmd,
  output logic                   lcd_cmd_valid,
  input  logic                   lcd_busy,
  input  logic                   lcd_done,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             cmd_cnt,
  output logic                   seq_done,
  output logic                   wdog_err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lcd_cmd_sched: DEPTH must be a power of two >= 2");
  end
  if (WDOG_CYC < 2) begin : g_bad_wdog
    $error("lcd_cmd_sched: WDOG_CYC must be >= 2");
  end

  state_t           state;
  state_t           state_next;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic             fin_entry;
  logic             timeout;
  logic [CMD_W-1:0] head;

  // Ready is held low during reset so the host never sees a phantom accept.
  assign host_ready = !reset && !full && (state != S_FIN);
  assign push       = host_valid && host_ready;
  assign fin_entry  = (state_next == S_FIN) && (state != S_FIN);

  sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (fin_entry),
    .push  (push),
    .wdata (host_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

`ifdef LCD_SCHED_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYC + 1);

  logic [WW-1:0] wdog_cnt;
  logic          in_wait;

  assign in_wait = (state == S_WAIT) || (state == S_DRAIN);
  assign timeout = in_wait && (wdog_cnt >= WW'(WDOG_CYC - 1));

  // Counts cycles spent waiting on the controller; restarts on each entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (((state_next == S_WAIT) || (state_next == S_DRAIN)) && (state_next != state))
        wdog_cnt <= '0;
      else if (in_wait)
        wdog_cnt <= wdog_cnt + WW'(1);
      wdog_err <= wdog_err | timeout;
    end
  end
`else
  assign timeout  = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_BOOT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      S_BOOT:  if (!lcd_busy) state_next = S_READY;
      S_READY: begin
        if (!empty && !lcd_busy) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = is_terminal(lcd_cmd) ? S_DRAIN : S_GUARD;
      S_GUARD: state_next = S_WAIT;
      S_WAIT:  if (!lcd_busy) state_next = S_READY;
      S_DRAIN: if (lcd_done) state_next = S_FIN;
      S_FIN:   state_next = S_FIN;
      default: state_next = S_BOOT;
    endcase
    if (timeout) state_next = S_FIN;
  end

  // Issue strobe, held command and saturating issue counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_cmd       <= '0;
      lcd_cmd_valid <= 1'b0;
      cmd_cnt       <= '0;
      seq_done      <= 1'b0;
    end else begin
      lcd_cmd_valid <= pop;
      seq_done      <= (state_next == S_FIN);
      if (pop) begin
        lcd_cmd <= head;
        if (cmd_cnt != 8'hFF) cmd_cnt <= cmd_cnt + 8'd1;
      end
    end
  end

endmodule
